hash_bucket_lookup: RTL and testbench

- Downstream stage of the key-hash unit. Pops one {hash1, hash2, hash3} triple from the hash FIFO per lookup.
- Indexes two bucket tables (cuckoo-style pair) with low bits of hash1 and hash2, reads both, and compares the stored tags against hash3.
- Writes one hit/miss result word to the result FIFO.
- Single engine, one lookup in flight, standard-mode (non-FWFT) FIFOs on both sides.

---
 rtl/hash_lookup_pkg.sv | 50 +++++
 rtl/hash_bucket_lookup_bucket_cmp.sv | 21 ++
 rtl/hash_bucket_lookup.sv | 187 ++++++++++++++++++
 tb/tb_hash_bucket_lookup.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hash_lookup_pkg.sv
// Shared definitions for the hash bucket lookup engine: FSM state encoding,
// entry/result field offsets and the width derivations used by every file.
// Optional insert-on-miss behaviour is built when HASH_LOOKUP_INSERT_EN is defined.
package hash_lookup_pkg;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_POP  = 3'd1,
      S_CAPT = 3'd2,
      S_READ = 3'd3,
      S_CMP  = 3'd4,
      S_INS  = 3'd5,
      S_OUT  = 3'd6
   } state_t;

   // Bucket entry is {valid, tag, ptr}
   function automatic int entryW(input int tagW, input int ptrW);
      return 1 + tagW + ptrW;
   endfunction

   // Result word is {hit, tbl, ovf, idx, ptr}
   function automatic int resW(input int addrW, input int ptrW);
      return 3 + addrW + ptrW;
   endfunction

   function automatic int entryValidBit(input int tagW, input int ptrW);
      return tagW + ptrW;
   endfunction

   function automatic int entryTagLsb(input int ptrW);
      return ptrW;
   endfunction

   function automatic int resHitBit(input int addrW, input int ptrW);
      return 2 + addrW + ptrW;
   endfunction

   function automatic int resTblBit(input int addrW, input int ptrW);
      return 1 + addrW + ptrW;
   endfunction

   function automatic int resOvfBit(input int addrW, input int ptrW);
      return addrW + ptrW;
   endfunction

   function automatic int resIdxLsb(input int ptrW);
      return ptrW;
   endfunction

endpackage

// File: rtl/hash_bucket_lookup_bucket_cmp.sv
// Combinational compare of one bucket entry against the lookup tag.
// Splits the entry into its valid bit and pointer for the lookup FSM.
module bucket_cmp
   import hash_lookup_pkg::*;
#(
   parameter int TAG_W = 5,
   parameter int PTR_W = 16,
   localparam int ENTRY_W = entryW(TAG_W, PTR_W)
) (
   input  logic [ENTRY_W-1:0] entry_i,
   input  logic [TAG_W-1:0]   tag_i,
   output logic               valid_o,
   output logic               hit_o,
   output logic [PTR_W-1:0]   ptr_o
);

   assign valid_o = entry_i[entryValidBit(TAG_W, PTR_W)];
   assign ptr_o   = entry_i[PTR_W-1:0];
   assign hit_o   = valid_o && (entry_i[entryTagLsb(PTR_W) +: TAG_W] == tag_i);

endmodule

// File: rtl/hash_bucket_lookup.sv
// Cuckoo-pair bucket lookup: pops one hash triple, reads both candidate
// buckets, compares tags and pushes one hit/miss result word.
// Define HASH_LOOKUP_INSERT_EN to insert the tag into a free bucket on a miss.
module hash_bucket_lookup
   import hash_lookup_pkg::*;
#(
   parameter int KEYHASH_WIDTH1 = 28,
   parameter int KEYHASH_WIDTH2 = 24,
   parameter int KEYHASH_WIDTH3 = 5,
   parameter int ADDR_W         = 10,
   parameter int PTR_W          = 16,
   localparam int ENTRY_W = entryW(KEYHASH_WIDTH3, PTR_W),
   localparam int RES_W   = resW(ADDR_W, PTR_W)
) (
   input  logic                      clk,
   input  logic                      rst,
   output logic                      oRdHashClk,
   input  logic                      iRdHashEmpty,
   output logic                      oRdHashFifo_en,
   input  logic [KEYHASH_WIDTH1-1:0] iKeyHash_1,
   input  logic [KEYHASH_WIDTH2-1:0] iKeyHash_2,
   input  logic [KEYHASH_WIDTH3-1:0] iKeyHash_3,
   output logic [ADDR_W-1:0]         oTbl1Addr,
   input  logic [ENTRY_W-1:0]        iTbl1Data,
   output logic                      oTbl1We,
   output logic [ENTRY_W-1:0]        oTbl1WrData,
   output logic [ADDR_W-1:0]         oTbl2Addr,
   input  logic [ENTRY_W-1:0]        iTbl2Data,
   output logic                      oTbl2We,
   output logic [ENTRY_W-1:0]        oTbl2WrData,
   output logic                      oWrResClk,
   input  logic                      iWrResFull,
   output logic                      oWrResFifo_en,
   output logic [RES_W-1:0]          oResult
);

   state_t                    state_q;
   logic                      rdEn_q;
   logic                      wrEn_q;
   logic [KEYHASH_WIDTH3-1:0] tag_q;
   logic [ADDR_W-1:0]         addr1_q;
   logic [ADDR_W-1:0]         addr2_q;
   logic [RES_W-1:0]          result_q;

   logic                      valid1, hit1, valid2, hit2;
   logic [PTR_W-1:0]          ptr1, ptr2;

   assign oRdHashClk     = clk;
   assign oWrResClk      = clk;
   assign oRdHashFifo_en = rdEn_q;
   assign oWrResFifo_en  = wrEn_q;
   assign oTbl1Addr      = addr1_q;
   assign oTbl2Addr      = addr2_q;
   assign oResult        = result_q;

   bucket_cmp #(.TAG_W(KEYHASH_WIDTH3), .PTR_W(PTR_W)) uCmp1 (
      .entry_i (iTbl1Data),
      .tag_i   (tag_q),
      .valid_o (valid1),
      .hit_o   (hit1),
      .ptr_o   (ptr1)
   );

   bucket_cmp #(.TAG_W(KEYHASH_WIDTH3), .PTR_W(PTR_W)) uCmp2 (
      .entry_i (iTbl2Data),
      .tag_i   (tag_q),
      .valid_o (valid2),
      .hit_o   (hit2),
      .ptr_o   (ptr2)
   );

`ifdef HASH_LOOKUP_INSERT_EN
   logic                 tbl1We_q;
   logic                 tbl2We_q;
   logic [ENTRY_W-1:0]   wrData_q;
   logic [PTR_W-1:0]     freePtr_q;

   assign oTbl1We     = tbl1We_q;
   assign oTbl2We     = tbl2We_q;
   assign oTbl1WrData = wrData_q;
   assign oTbl2WrData = wrData_q;

   logic unused_hashBits;
   assign unused_hashBits = ^{iKeyHash_1[KEYHASH_WIDTH1-1:ADDR_W],
                              iKeyHash_2[KEYHASH_WIDTH2-1:ADDR_W]};
`else
   assign oTbl1We     = 1'b0;
   assign oTbl2We     = 1'b0;
   assign oTbl1WrData = '0;
   assign oTbl2WrData = '0;

   logic unused_hashBits;
   assign unused_hashBits = ^{iKeyHash_1[KEYHASH_WIDTH1-1:ADDR_W],
                              iKeyHash_2[KEYHASH_WIDTH2-1:ADDR_W],
                              valid1, valid2};
`endif

   // Lookup sequencer: every output is a register updated here, so the FIFO
   // and table strobes come out glitch-free and one state after the decision.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         rdEn_q   <= 1'b0;
         wrEn_q   <= 1'b0;
         tag_q    <= '0;
         addr1_q  <= '0;
         addr2_q  <= '0;
         result_q <= '0;
`ifdef HASH_LOOKUP_INSERT_EN
         tbl1We_q  <= 1'b0;
         tbl2We_q  <= 1'b0;
         wrData_q  <= '0;
         freePtr_q <= '0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               wrEn_q <= 1'b0;
               if (!iRdHashEmpty) begin
                  rdEn_q  <= 1'b1;
                  state_q <= S_POP;
               end
            end
            S_POP: begin
               rdEn_q  <= 1'b0;
               state_q <= S_CAPT;
            end
            S_CAPT: begin
               tag_q   <= iKeyHash_3;
               addr1_q <= iKeyHash_1[ADDR_W-1:0];
               addr2_q <= iKeyHash_2[ADDR_W-1:0];
               state_q <= S_READ;
            end
            S_READ: begin
               state_q <= S_CMP;
            end
            S_CMP: begin
               if (hit1) begin
                  result_q <= {1'b1, 1'b0, 1'b0, addr1_q, ptr1};
                  state_q  <= S_OUT;
               end else if (hit2) begin
                  result_q <= {1'b1, 1'b1, 1'b0, addr2_q, ptr2};
                  state_q  <= S_OUT;
               end else begin
`ifdef HASH_LOOKUP_INSERT_EN
                  wrData_q <= {1'b1, tag_q, freePtr_q};
                  if (!valid1) begin
                     tbl1We_q <= 1'b1;
                     result_q <= {1'b0, 1'b0, 1'b0, addr1_q, freePtr_q};
                  end else if (!valid2) begin
                     tbl2We_q <= 1'b1;
                     result_q <= {1'b0, 1'b1, 1'b0, addr2_q, freePtr_q};
                  end else begin
                     result_q <= {1'b0, 1'b0, 1'b1, addr1_q, {PTR_W{1'b0}}};
                  end
                  state_q <= S_INS;
`else
                  result_q <= {1'b0, 1'b0, 1'b0, addr1_q, {PTR_W{1'b0}}};
                  state_q  <= S_OUT;
`endif
               end
            end
`ifdef HASH_LOOKUP_INSERT_EN
            S_INS: begin
               tbl1We_q <= 1'b0;
               tbl2We_q <= 1'b0;
               wrData_q <= '0;
               if (tbl1We_q || tbl2We_q) begin
                  freePtr_q <= freePtr_q + 1'b1;
               end
               state_q <= S_OUT;
            end
`endif
            S_OUT: begin
               if (!iWrResFull) begin
                  wrEn_q  <= 1'b1;
                  state_q <= S_IDLE;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hash_bucket_lookup.sv
// Self-checking bench for hash_bucket_lookup with FIFO and table models.
// Honours HASH_LOOKUP_INSERT_EN for the insert-on-miss expectations.
module tb_hash_bucket_lookup;

   localparam int W1 = 28;
   localparam int W2 = 24;
   localparam int W3 = 5;
   localparam int AW = 10;
   localparam int PW = 16;
   localparam int EW = 1 + W3 + PW;
   localparam int RW = 3 + AW + PW;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          rdHashClk, wrResClk;
   logic          hashEmpty;
   logic          rdEn;
   logic [W1-1:0] keyHash1 = '0;
   logic [W2-1:0] keyHash2 = '0;
   logic [W3-1:0] keyHash3 = '0;
   logic [AW-1:0] tbl1Addr, tbl2Addr;
   logic [EW-1:0] tbl1Data = '0;
   logic [EW-1:0] tbl2Data = '0;
   logic          tbl1We, tbl2We;
   logic [EW-1:0] tbl1WrData, tbl2WrData;
   logic          resFull = 1'b0;
   logic          wrEn;
   logic [RW-1:0] result;

   int errors = 0;
   int checks = 0;

   // Bench-side table memories and their preload/clear controls
   logic [EW-1:0] mem1 [0:1023];
   logic [EW-1:0] mem2 [0:1023];
   logic          clr = 1'b1;
   logic          pre1 = 1'b0;
   logic          pre2 = 1'b0;
   logic [AW-1:0] preAddr = '0;
   logic [EW-1:0] preData = '0;

   // Hash FIFO contents (written by stimulus, popped by the FIFO model)
   logic [W1-1:0] fq1 [0:15];
   logic [W2-1:0] fq2 [0:15];
   logic [W3-1:0] fq3 [0:15];
   int pushCnt = 0;
   int popCnt  = 0;

   // Reference tables and expected result stream
   logic [EW-1:0] ref1 [0:1023];
   logic [EW-1:0] ref2 [0:1023];
   int            refFree = 0;
   int            modelWe = 0;
   logic [RW-1:0] expRes [0:31];
   int            expLat [0:31];
   int            expWr = 0;
   int            expRd = 0;

   int cycle   = 0;
   int rdCycle = 0;
   int rdCount = 0;
   int weCount = 0;

`ifdef HASH_LOOKUP_INSERT_EN
   localparam logic [RW-1:0] T4_EXP = {1'b0, 1'b0, 1'b1, 10'h123, 16'h0000};
   localparam logic [RW-1:0] T5_EXP = {1'b0, 1'b1, 1'b0, 10'h2AA, 16'h0001};
`else
   localparam logic [RW-1:0] T4_EXP = {1'b0, 1'b0, 1'b0, 10'h123, 16'h0000};
   localparam logic [RW-1:0] T5_EXP = {1'b0, 1'b0, 1'b0, 10'h123, 16'h0000};
`endif

   hash_bucket_lookup dut (
      .clk            (clk),
      .rst            (rst),
      .oRdHashClk     (rdHashClk),
      .iRdHashEmpty   (hashEmpty),
      .oRdHashFifo_en (rdEn),
      .iKeyHash_1     (keyHash1),
      .iKeyHash_2     (keyHash2),
      .iKeyHash_3     (keyHash3),
      .oTbl1Addr      (tbl1Addr),
      .iTbl1Data      (tbl1Data),
      .oTbl1We        (tbl1We),
      .oTbl1WrData    (tbl1WrData),
      .oTbl2Addr      (tbl2Addr),
      .iTbl2Data      (tbl2Data),
      .oTbl2We        (tbl2We),
      .oTbl2WrData    (tbl2WrData),
      .oWrResClk      (wrResClk),
      .iWrResFull     (resFull),
      .oWrResFifo_en  (wrEn),
      .oResult        (result)
   );

   always #5 clk = ~clk;

   assign hashEmpty = (pushCnt == popCnt);

   // Table memories: one-cycle registered read, DUT writes win over preloads
   always @(posedge clk) begin
      tbl1Data <= mem1[tbl1Addr];
      tbl2Data <= mem2[tbl2Addr];
      if (clr) begin
         for (int i = 0; i < 1024; i++) begin
            mem1[i] <= '0;
            mem2[i] <= '0;
         end
      end else begin
         if (tbl1We) mem1[tbl1Addr] <= tbl1WrData;
         else if (pre1) mem1[preAddr] <= preData;
         if (tbl2We) mem2[tbl2Addr] <= tbl2WrData;
         else if (pre2) mem2[preAddr] <= preData;
      end
   end

   // Standard-mode hash FIFO: data appears the cycle after the read strobe
   always @(posedge clk) begin
      if (rdEn && (popCnt < pushCnt)) begin
         keyHash1 <= fq1[popCnt % 16];
         keyHash2 <= fq2[popCnt % 16];
         keyHash3 <= fq3[popCnt % 16];
         popCnt   <= popCnt + 1;
      end
   end

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   // Spec-level lookup model over the reference tables
   task automatic modelLookup(input logic [W1-1:0] h1, input logic [W2-1:0] h2,
                              input logic [W3-1:0] h3, output logic [RW-1:0] res,
                              output int lat);
      logic [AW-1:0] i1, i2;
      logic [EW-1:0] e1, e2;
      logic          v1, v2;
      i1 = h1[AW-1:0];
      i2 = h2[AW-1:0];
      e1 = ref1[i1];
      e2 = ref2[i2];
      v1 = e1[EW-1];
      v2 = e2[EW-1];
      lat = 5;
      if (v1 && e1[PW +: W3] == h3) begin
         res = {1'b1, 1'b0, 1'b0, i1, e1[PW-1:0]};
      end else if (v2 && e2[PW +: W3] == h3) begin
         res = {1'b1, 1'b1, 1'b0, i2, e2[PW-1:0]};
      end else begin
`ifdef HASH_LOOKUP_INSERT_EN
         lat = 6;
         if (!v1) begin
            ref1[i1] = {1'b1, h3, refFree[PW-1:0]};
            res = {1'b0, 1'b0, 1'b0, i1, refFree[PW-1:0]};
            refFree = (refFree + 1) % 65536;
            modelWe++;
         end else if (!v2) begin
            ref2[i2] = {1'b1, h3, refFree[PW-1:0]};
            res = {1'b0, 1'b1, 1'b0, i2, refFree[PW-1:0]};
            refFree = (refFree + 1) % 65536;
            modelWe++;
         end else begin
            res = {1'b0, 1'b0, 1'b1, i1, 16'h0000};
         end
`else
         res = {1'b0, 1'b0, 1'b0, i1, 16'h0000};
`endif
      end
   endtask

   task automatic pushHashOnly(input logic [W1-1:0] h1, input logic [W2-1:0] h2, input logic [W3-1:0] h3);
      @(posedge clk); #2;
      fq1[pushCnt % 16] = h1;
      fq2[pushCnt % 16] = h2;
      fq3[pushCnt % 16] = h3;
      pushCnt++;
   endtask

   task automatic applyStimulus(input logic [W1-1:0] h1, input logic [W2-1:0] h2,
                                input logic [W3-1:0] h3, input bit checkLat);
      logic [RW-1:0] res;
      int lat;
      modelLookup(h1, h2, h3, res, lat);
      expRes[expWr % 32] = res;
      expLat[expWr % 32] = checkLat ? lat : 0;
      expWr++;
      pushHashOnly(h1, h2, h3);
   endtask

   task automatic preload(input int tbl, input logic [AW-1:0] addr, input logic [EW-1:0] data);
      @(posedge clk); #2;
      preAddr = addr;
      preData = data;
      if (tbl == 1) begin
         pre1 = 1'b1;
         ref1[addr] = data;
      end else begin
         pre2 = 1'b1;
         ref2[addr] = data;
      end
      @(posedge clk); #2;
      pre1 = 1'b0;
      pre2 = 1'b0;
   endtask

   task automatic waitResults(input int target, input int budget);
      int n = 0;
      while (expRd < target && n < budget) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      if (expRd < target) begin
         checks++;
         errors++;
         $display("[TB] FAIL resultTimeout: got %0d results expected %0d", expRd, target);
      end
   endtask

   // Per-cycle compare process: strobe shapes, result stream and latency
   initial begin
      bit prevRd = 1'b0;
      bit prevWr = 1'b0;
      forever begin
         @(negedge clk);
         cycle++;
         if (rst) begin
            prevRd = 1'b0;
            prevWr = 1'b0;
         end else begin
            if (rdEn) begin
               checkOutput("rdSinglePulse", 64'(prevRd), 64'd0);
               rdCycle = cycle;
               rdCount++;
            end
            if (wrEn) begin
               checkOutput("wrSinglePulse", 64'(prevWr), 64'd0);
               checkOutput("wrWhileFull", 64'(resFull), 64'd0);
               checkOutput("popWithWrite", 64'(rdEn), 64'd0);
               if (expRd == expWr) begin
                  checks++;
                  errors++;
                  $display("[TB] FAIL unexpectedResult: got %0h expected no write", result);
               end else begin
                  checkOutput("result", 64'(result), 64'(expRes[expRd % 32]));
                  if (expLat[expRd % 32] != 0)
                     checkOutput("latency", 64'(cycle - rdCycle), 64'(expLat[expRd % 32]));
                  expRd++;
               end
            end
            if (tbl1We || tbl2We) weCount++;
            prevRd = rdEn;
            prevWr = wrEn;
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int n;
      int weBefore;
      for (int i = 0; i < 1024; i++) begin
         ref1[i] = '0;
         ref2[i] = '0;
      end

      // Reset state
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("rstRdEn",   64'(rdEn), 64'd0);
      checkOutput("rstWrEn",   64'(wrEn), 64'd0);
      checkOutput("rstWe",     64'({tbl1We, tbl2We}), 64'd0);
      checkOutput("rstAddr",   64'({tbl1Addr, tbl2Addr}), 64'd0);
      checkOutput("rstResult", 64'(result), 64'd0);
      checkOutput("rstWrData", 64'({tbl1WrData, tbl2WrData}), 64'd0);
      checkOutput("clkOut",    64'({rdHashClk, wrResClk}), 64'({clk, clk}));
      @(posedge clk); #2;
      rst = 1'b0;
      clr = 1'b0;

      // Empty tables: miss (or insert into table1 with pointer 0)
      $display("[TB] test 1: empty tables");
      applyStimulus(28'h0000123, 24'h000045, 5'h0A, 1'b1);
      waitResults(1, 40);
      checkOutput("t1Literal", 64'(result), 64'({1'b0, 1'b0, 1'b0, 10'h123, 16'h0000}));
`ifdef HASH_LOOKUP_INSERT_EN
      checkOutput("t1Tbl1Entry", 64'(mem1[10'h123]), 64'({1'b1, 5'h0A, 16'h0000}));
`endif

      // Both buckets hit: table1 wins
      $display("[TB] test 2: double hit");
      preload(1, 10'h123, {1'b1, 5'h0A, 16'h1234});
      preload(2, 10'h045, {1'b1, 5'h0A, 16'h5678});
      applyStimulus(28'h0000123, 24'h000045, 5'h0A, 1'b1);
      waitResults(2, 40);
      checkOutput("t2Literal", 64'(result), 64'({1'b1, 1'b0, 1'b0, 10'h123, 16'h1234}));

      // Table1 tag mismatch, table2 hit
      $display("[TB] test 3: table2 hit");
      preload(1, 10'h123, {1'b1, 5'h0B, 16'h1234});
      preload(2, 10'h045, {1'b1, 5'h0A, 16'h00FF});
      applyStimulus(28'h0000123, 24'h000045, 5'h0A, 1'b1);
      waitResults(3, 40);
      checkOutput("t3Literal", 64'(result), 64'({1'b1, 1'b1, 1'b0, 10'h045, 16'h00FF}));

      // Both buckets valid with other tags: overflow, no table write
      $display("[TB] test 4: both occupied");
      weBefore = weCount;
      applyStimulus(28'h0000123, 24'h000045, 5'h0C, 1'b1);
      waitResults(4, 40);
      checkOutput("t4Literal", 64'(result), 64'(T4_EXP));
      checkOutput("t4NoWrite", 64'(weCount), 64'(weBefore));

      // Table1 occupied, table2 free: insert lands in table2
      $display("[TB] test 5: table2 free");
      applyStimulus(28'h0000123, 24'h0002AA, 5'h0C, 1'b1);
      waitResults(5, 40);
      checkOutput("t5Literal", 64'(result), 64'(T5_EXP));
`ifdef HASH_LOOKUP_INSERT_EN
      checkOutput("t5Tbl2Entry", 64'(mem2[10'h2AA]), 64'({1'b1, 5'h0C, 16'h0001}));
`endif

      // Result FIFO backpressure
      $display("[TB] test 6: backpressure");
      @(posedge clk); #2;
      resFull = 1'b1;
      applyStimulus(28'h0000200, 24'h000300, 5'h11, 1'b0);
      repeat (10) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checkOutput("stallResult", 64'(result), 64'(expRes[(expWr - 1) % 32]));
         checkOutput("stallNoWrite", 64'(wrEn), 64'd0);
      end
      @(posedge clk); #2;
      resFull = 1'b0;
      waitResults(6, 20);

      // Reset during table read: lookup abandoned, nothing written
      $display("[TB] test 7: reset mid-lookup");
      weBefore = weCount;
      pushHashOnly(28'h0000155, 24'h000166, 5'h03);
      n = 0;
      while (!rdEn && n < 20) begin
         @(negedge clk);
         n++;
      end
      checkOutput("t7PopSeen", 64'(rdEn), 64'd1);
      @(posedge clk);
      @(posedge clk); #2;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checkOutput("t7RstRdEn",   64'(rdEn), 64'd0);
      checkOutput("t7RstWrEn",   64'(wrEn), 64'd0);
      checkOutput("t7RstWe",     64'({tbl1We, tbl2We}), 64'd0);
      checkOutput("t7RstAddr",   64'({tbl1Addr, tbl2Addr}), 64'd0);
      checkOutput("t7RstResult", 64'(result), 64'd0);
      @(posedge clk); #2;
      rst = 1'b0;
      repeat (12) @(negedge clk);
      checkOutput("t7NoWrite", 64'(weCount), 64'(weBefore));

      // Back-to-back lookups after recovery
      $display("[TB] test 8: back-to-back");
      applyStimulus(28'h0000123, 24'h000045, 5'h0B, 1'b1);
      applyStimulus(28'h0000123, 24'h000045, 5'h0A, 1'b1);
      waitResults(8, 60);
      checkOutput("t8Literal", 64'(result), 64'({1'b1, 1'b1, 1'b0, 10'h045, 16'h00FF}));

      checkOutput("popCount", 64'(rdCount), 64'(pushCnt));
      checkOutput("weCount", 64'(weCount), 64'(modelWe));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
